// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM.
// Moore decode of the state register drives all datapath enables and mux
// selects. The only Mealy terms are the FETCH-stage IR/PC loads, which are
// gated by mem_ready so a stalled fetch does not disturb the IR or PC.
// Also flags unsupported opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_BEQ_EX   = 4'd8;
  localparam logic [3:0] S_ADDI_EX  = 4'd9;
  localparam logic [3:0] S_ADDI_WB  = 4'd10;
  localparam logic [3:0] S_JUMP_EX  = 4'd11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             w_illegal;
  logic             w_retire;
  logic             r_illegal_op;
  logic [CNT_W-1:0] r_instr_count;

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) w_next = S_MEMADR;
        else if (op == OP_RTYPE)        w_next = S_RTYPE_EX;
        else if (op == OP_BEQ)          w_next = S_BEQ_EX;
        else if (op == OP_ADDI)         w_next = S_ADDI_EX;
        else if (op == OP_J)            w_next = S_JUMP_EX;
        else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_RTYPE_EX: w_next = S_RTYPE_WB;
      S_RTYPE_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_BEQ_EX: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_JUMP_EX: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:    w_next = S_FETCH;
    endcase
  end

  // State, illegal-opcode pulse and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_illegal_op  <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= w_illegal;
      if (w_retire) r_instr_count <= r_instr_count + CNT_ONE;
    end
  end

  // Moore output decode; everything not named for a state stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:  reg_write = 1'b1;
      S_JUMP_EX: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal_op;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl. The driver walks hand-written
// instruction sequences and pushes the expected per-cycle response; the
// monitor pops and compares on the falling edge. A second instance with a
// 3-bit counter exercises the counter wrap.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  logic        b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write;
  logic        b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a;
  logic [1:0]  b_alu_src_b, b_alu_op, b_pc_source;
  logic [3:0]  b_state;
  logic        b_illegal_op;
  logic [2:0]  b_instr_count;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .i_or_d(b_i_or_d),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .mem_to_reg(b_mem_to_reg), .reg_dst(b_reg_dst), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .pc_source(b_pc_source), .state(b_state), .illegal_op(b_illegal_op),
    .instr_count(b_instr_count)
  );

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written control table: {pc_write, pc_write_cond, i_or_d, mem_read,
  // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
  // alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic mr);
    case (s)
      4'd0:  exp_ctl = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
      4'd1:  exp_ctl = {10'b0000000000, 2'b11, 2'b00, 2'b00};
      4'd2:  exp_ctl = {10'b0000000001, 2'b10, 2'b00, 2'b00};
      4'd3:  exp_ctl = {10'b0011000000, 2'b00, 2'b00, 2'b00};
      4'd4:  exp_ctl = {10'b0000001010, 2'b00, 2'b00, 2'b00};
      4'd5:  exp_ctl = {10'b0010100000, 2'b00, 2'b00, 2'b00};
      4'd6:  exp_ctl = {10'b0000000001, 2'b00, 2'b10, 2'b00};
      4'd7:  exp_ctl = {10'b0000000110, 2'b00, 2'b00, 2'b00};
      4'd8:  exp_ctl = {10'b0100000001, 2'b00, 2'b01, 2'b01};
      4'd9:  exp_ctl = {10'b0000000001, 2'b10, 2'b00, 2'b00};
      4'd10: exp_ctl = {10'b0000000010, 2'b00, 2'b00, 2'b00};
      4'd11: exp_ctl = {10'b1000000000, 2'b00, 2'b00, 2'b10};
      default: exp_ctl = 16'h0000;
    endcase
  endfunction

  task automatic expect_now(input logic [3:0] s, input logic mr, input int c, input logic ill);
    exp_t e;
    e.st  = s;
    e.ctl = exp_ctl(s, mr);
    e.cnt = c;
    e.ill = ill;
    q.push_back(e);
  endtask

  // Drive one cycle and record what the DUT must show during it.
  task automatic step(input logic [5:0] o, input logic mr, input logic [3:0] s, input logic ill);
    op = o;
    mem_ready = mr;
    expect_now(s, mr, cnt, ill);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act, act_w;
      e = q.pop_front();
      act   = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
      act_w = {b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write,
               b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_source};
      checks += 7;
      if (state !== e.st) begin
        errors++; $display("FAIL state t=%0t got %0d want %0d", $time, state, e.st);
      end
      if (act !== e.ctl) begin
        errors++; $display("FAIL ctl st=%0d t=%0t got %b want %b", e.st, $time, act, e.ctl);
      end
      if (instr_count !== e.cnt) begin
        errors++; $display("FAIL instr_count t=%0t got %0d want %0d", $time, instr_count, e.cnt);
      end
      if (illegal_op !== e.ill) begin
        errors++; $display("FAIL illegal_op t=%0t got %b want %b", $time, illegal_op, e.ill);
      end
      if (b_instr_count !== e.cnt[2:0]) begin
        errors++; $display("FAIL count3 t=%0t got %0d want %0d", $time, b_instr_count, e.cnt[2:0]);
      end
      if ({b_state, act_w, b_illegal_op} !== {e.st, e.ctl, e.ill}) begin
        errors++; $display("FAIL narrow_inst t=%0t got %h want %h", $time,
                           {b_state, act_w, b_illegal_op}, {e.st, e.ctl, e.ill});
      end
      if (mem_read && mem_write) begin
        errors++; $display("FAIL rd_wr_excl t=%0t got 1 want 0", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    op = RT;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    expect_now(4'd0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type: 0,1,6,7,0
    step(RT, 1, 0, 0); step(RT, 1, 1, 0); step(RT, 1, 6, 0); step(RT, 1, 7, 0);
    cnt = 1;
    // lw with a 3-cycle stall in MEMRD
    step(LW, 1, 0, 0); step(LW, 1, 1, 0); step(LW, 1, 2, 0);
    step(LW, 0, 3, 0); step(LW, 0, 3, 0); step(LW, 0, 3, 0); step(LW, 1, 3, 0);
    step(LW, 1, 4, 0);
    cnt = 2;
    // sw with a 2-cycle stall in FETCH and one in MEMWR
    step(SW, 0, 0, 0); step(SW, 0, 0, 0); step(SW, 1, 0, 0);
    step(SW, 1, 1, 0); step(SW, 1, 2, 0); step(SW, 0, 5, 0); step(SW, 1, 5, 0);
    cnt = 3;
    // beq then j
    step(BQ, 1, 0, 0); step(BQ, 1, 1, 0); step(BQ, 1, 8, 0);
    cnt = 4;
    step(JP, 1, 0, 0); step(JP, 1, 1, 0); step(JP, 1, 11, 0);
    cnt = 5;
    // addi
    step(AD, 1, 0, 0); step(AD, 1, 1, 0); step(AD, 1, 9, 0); step(AD, 1, 10, 0);
    cnt = 6;
    // illegal opcode: one-cycle pulse, no retire; then an R-type
    step(BAD, 1, 0, 0); step(BAD, 1, 1, 0); step(BAD, 1, 0, 1);
    step(RT, 1, 1, 0); step(RT, 1, 6, 0); step(RT, 1, 7, 0);
    cnt = 7;
    // eighth retire wraps the 3-bit counter to 0
    step(JP, 1, 0, 0); step(JP, 1, 1, 0); step(JP, 1, 11, 0);
    cnt = 8;
    // reset mid-RTYPE_EX: immediate return to FETCH with counter cleared
    step(RT, 1, 0, 0); step(RT, 1, 1, 0);
    op = RT; mem_ready = 1'b1;
    reset = 1'b1;
    cnt = 0;
    expect_now(4'd0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    expect_now(4'd0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(RT, 1, 0, 0); step(RT, 1, 1, 0);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
